// File: rtl/bcd_scan_display_if.sv
// Digit/mask inputs and multiplexed display outputs of the BCD scan display.
// The master side supplies digits and masks; the slave side drives the display.
interface bcd_scan_display_if;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic [3:0] dp_mask;
  logic [3:0] blink_mask;
  logic       lzb_en;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_tick;

  modport master (
    output digit0, digit1, digit2, digit3, dp_mask, blink_mask, lzb_en,
    input  an, seg, dp, frame_tick
  );

  modport slave (
    input  digit0, digit1, digit2, digit3, dp_mask, blink_mask, lzb_en,
    output an, seg, dp, frame_tick
  );
endinterface

// File: rtl/bcd_scan_display.sv
// Time-multiplexes four BCD digits onto a 4-digit common-anode 7-segment
// display. Digits and masks are captured once per frame so a frame never
// shows a mix of old and new values. Each digit slot opens with a guard
// interval (all anodes off) to stop ghosting when the anode switches.
module bcd_scan_display #(
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD        = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                src_clk,
  input  logic                src_rst,
  bcd_scan_display_if.slave   bus
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int FW = $clog2(BLINK_FRAMES + 1);

  localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GUARD_CNT  = CW'(GUARD);
  localparam logic [FW-1:0] FRAMES_MAX = FW'(BLINK_FRAMES);

  // Scan timing
  logic [CW-1:0]   cnt;
  logic [1:0]      idx;
  logic            frame_start;

  // Per-frame shadow copies of the inputs
  logic [3:0][3:0] sh_digit;
  logic [3:0]      sh_dp;
  logic [3:0]      sh_blink;
  logic            sh_lzb;

  // Blink state: fcnt counts frames shown so far in the current phase
  logic [FW-1:0]   fcnt;
  logic            phase;

  // Next values for the registered display outputs
  logic [3:0]      next_an;
  logic [6:0]      next_seg;
  logic            next_dp;
  logic            lz_hide;
  logic            blink_hide;

  // Active-low segment pattern {g,f,e,d,c,b,a}; non-BCD codes show a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h40;
      4'd1:    seg_decode = 7'h79;
      4'd2:    seg_decode = 7'h24;
      4'd3:    seg_decode = 7'h30;
      4'd4:    seg_decode = 7'h19;
      4'd5:    seg_decode = 7'h12;
      4'd6:    seg_decode = 7'h02;
      4'd7:    seg_decode = 7'h78;
      4'd8:    seg_decode = 7'h00;
      4'd9:    seg_decode = 7'h10;
      default: seg_decode = 7'h3F;
    endcase
  endfunction

  assign frame_start    = (idx == 2'd0) && (cnt == '0);
  assign bus.frame_tick = frame_start;

  // Advance the slot counter and step to the next digit at the end of each slot.
  always_ff @(posedge src_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (src_rst) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Capture the inputs and advance the blink phase once per frame start.
  always_ff @(posedge src_clk) begin
    if (src_rst) begin
      sh_digit <= '0;
      sh_dp    <= '0;
      sh_blink <= '0;
      sh_lzb   <= 1'b0;
      fcnt     <= '0;
      phase    <= 1'b0;
    end else if (frame_start) begin
      sh_digit <= {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
      sh_dp    <= bus.dp_mask;
      sh_blink <= bus.blink_mask;
      sh_lzb   <= bus.lzb_en;
      // The frame starting now is the first of a new phase once the current
      // phase has already been shown for BLINK_FRAMES frames.
      if (fcnt == FRAMES_MAX) begin
        phase <= ~phase;
        fcnt  <= FW'(1);
      end else begin
        fcnt  <= fcnt + FW'(1);
      end
    end
  end

  // Decide what the current slot shows: guard, hidden digit, or decoded digit.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    next_an    = 4'b1111;
    next_seg   = 7'h7F;
    next_dp    = 1'b1;
    lz_hide    = 1'b0;
    blink_hide = phase && sh_blink[idx];

    // A digit is a leading zero only if it and every digit to its left are 0.
    if (sh_lzb) begin
      case (idx)
        2'd3:    lz_hide = (sh_digit[3] == 4'd0);
        2'd2:    lz_hide = (sh_digit[3] == 4'd0) && (sh_digit[2] == 4'd0);
        2'd1:    lz_hide = (sh_digit[3] == 4'd0) && (sh_digit[2] == 4'd0)
                           && (sh_digit[1] == 4'd0);
        default: lz_hide = 1'b0;
      endcase
    end

    if ((cnt >= GUARD_CNT) && !lz_hide && !blink_hide) begin
      next_an  = ~(4'b0001 << idx);
      next_seg = seg_decode(sh_digit[idx]);
      next_dp  = ~sh_dp[idx];
    end
  end

  // Register the display drive so the pins change cleanly on the clock edge.
  always_ff @(posedge src_clk) begin
    if (src_rst) begin
      bus.an  <= 4'b1111;
      bus.seg <= 7'h7F;
      bus.dp  <= 1'b1;
    end else begin
      bus.an  <= next_an;
      bus.seg <= next_seg;
      bus.dp  <= next_dp;
    end
  end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Self-checking bench for bcd_scan_display with a short refresh period.
module tb_bcd_scan_display;

  localparam int RD    = 8;
  localparam int GD    = 2;
  localparam int BF    = 2;
  localparam int FRAME = 4 * RD;

  typedef struct packed {
    logic [3:0][3:0] d;
    logic [3:0]      dpm;
    logic [3:0]      blm;
    logic            lzb;
  } cfg_t;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } out_t;

  typedef struct packed {
    cfg_t            cfg;
    out_t [3:0]      want;
  } vec_t;

  localparam out_t OFF = '{an: 4'hF, seg: 7'h7F, dp: 1'b1};

  logic src_clk = 1'b0;
  logic src_rst;

  always #5 src_clk = ~src_clk;

  bcd_scan_display_if bus ();

  bcd_scan_display #(
    .REFRESH_DIV  (RD),
    .GUARD        (GD),
    .BLINK_FRAMES (BF)
  ) dut (
    .src_clk (src_clk),
    .src_rst (src_rst),
    .bus     (bus)
  );

  int   vectors     = 0;
  int   miscompares = 0;
  int   t           = 0;   // cycles since the last reset release
  cfg_t cur;               // inputs currently driven
  cfg_t sh;                // model copy of the inputs captured at frame start
  vec_t vecs [8];

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: seg_of = 7'h40;  4'd1: seg_of = 7'h79;
      4'd2: seg_of = 7'h24;  4'd3: seg_of = 7'h30;
      4'd4: seg_of = 7'h19;  4'd5: seg_of = 7'h12;
      4'd6: seg_of = 7'h02;  4'd7: seg_of = 7'h78;
      4'd8: seg_of = 7'h00;  4'd9: seg_of = 7'h10;
      default: seg_of = 7'h3F;
    endcase
  endfunction

  function automatic out_t o(input logic [3:0] an, input logic [6:0] seg, input logic dp);
    o = '{an: an, seg: seg, dp: dp};
  endfunction

  function automatic cfg_t mkcfg(input int d3, input int d2, input int d1, input int d0,
                                 input logic [3:0] dpm, input logic [3:0] blm, input logic lzb);
    cfg_t c;
    c.d[3] = 4'(d3); c.d[2] = 4'(d2); c.d[1] = 4'(d1); c.d[0] = 4'(d0);
    c.dpm = dpm; c.blm = blm; c.lzb = lzb;
    return c;
  endfunction

  // Expected outputs in cycle tt: the display shows the state of cycle tt-1.
  function automatic out_t model(input int tt);
    out_t r;
    int   s, pos, k, c, f, lead;
    logic hide;
    r = OFF;
    if (tt == 0) return r;
    s   = tt - 1;
    pos = s % FRAME;
    k   = pos / RD;
    c   = pos % RD;
    f   = s / FRAME;
    if (c < GD) return r;
    hide = (((f / BF) % 2) == 1) && sh.blm[k];
    lead = 0;
    for (int i = 3; i >= 1; i--) begin
      if (sh.d[i] != 4'd0) break;
      lead++;
    end
    if (sh.lzb && (k >= 4 - lead)) hide = 1'b1;
    if (hide) return r;
    r.an[k] = 1'b0;
    r.seg   = seg_of(sh.d[k]);
    r.dp    = ~sh.dpm[k];
    return r;
  endfunction

  task automatic apply(input cfg_t c);
    cur            = c;
    bus.digit0     = c.d[0];
    bus.digit1     = c.d[1];
    bus.digit2     = c.d[2];
    bus.digit3     = c.d[3];
    bus.dp_mask    = c.dpm;
    bus.blink_mask = c.blm;
    bus.lzb_en     = c.lzb;
  endtask

  task automatic check(input string name, input out_t want);
    vectors++;
    if ({bus.an, bus.seg, bus.dp} !== want) begin
      miscompares++;
      $display("FAIL %s t=%0d: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
               name, t, bus.an, bus.seg, bus.dp, want.an, want.seg, want.dp);
    end
  endtask

  task automatic check_tick(input logic want);
    vectors++;
    if (bus.frame_tick !== want) begin
      miscompares++;
      $display("FAIL frame_tick t=%0d: got %b, expected %b", t, bus.frame_tick, want);
    end
  endtask

  // Negedge of cycle t: compare against the model, then mirror the shadow load.
  task automatic at_neg();
    @(negedge src_clk);
    check("model", model(t));
    check_tick(t % FRAME == 0);
    if (t % FRAME == 0) sh = cur;
  endtask

  task automatic to_next();
    @(posedge src_clk);
    #1;
    t++;
  endtask

  task automatic cycle();
    at_neg();
    to_next();
  endtask

  task automatic align_frame();
    while (t % FRAME != 0) cycle();
  endtask

  // Hold reset for n edges checking the blanked outputs, then release.
  task automatic do_reset(input int n);
    src_rst = 1'b1;
    repeat (n) begin
      @(posedge src_clk);
      #1;
      check("reset", OFF);
    end
    src_rst = 1'b0;
    t = 0;
  endtask

  task automatic set_vec(input int i, input cfg_t c,
                         input out_t w0, input out_t w1, input out_t w2, input out_t w3);
    vecs[i].cfg     = c;
    vecs[i].want[0] = w0;
    vecs[i].want[1] = w1;
    vecs[i].want[2] = w2;
    vecs[i].want[3] = w3;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    cfg_t c;
    set_vec(0, mkcfg(1, 2, 3, 4, 4'b0000, 4'b0000, 1'b0),
            o(4'hE, 7'h19, 1), o(4'hD, 7'h30, 1), o(4'hB, 7'h24, 1), o(4'h7, 7'h79, 1));
    set_vec(1, mkcfg(1, 2, 3, 9, 4'b0010, 4'b0000, 1'b0),
            o(4'hE, 7'h10, 1), o(4'hD, 7'h30, 0), o(4'hB, 7'h24, 1), o(4'h7, 7'h79, 1));
    set_vec(2, mkcfg(0, 0, 7, 0, 4'b0000, 4'b0000, 1'b1),
            o(4'hE, 7'h40, 1), o(4'hD, 7'h78, 1), OFF, OFF);
    set_vec(3, mkcfg(0, 0, 0, 0, 4'b0000, 4'b0000, 1'b1),
            o(4'hE, 7'h40, 1), OFF, OFF, OFF);
    set_vec(4, mkcfg(1, 2, 3, 10, 4'b0000, 4'b0000, 1'b0),
            o(4'hE, 7'h3F, 1), o(4'hD, 7'h30, 1), o(4'hB, 7'h24, 1), o(4'h7, 7'h79, 1));
    set_vec(5, mkcfg(15, 0, 0, 0, 4'b0000, 4'b0000, 1'b1),
            o(4'hE, 7'h40, 1), o(4'hD, 7'h40, 1), o(4'hB, 7'h40, 1), o(4'h7, 7'h3F, 1));
    set_vec(6, mkcfg(0, 0, 0, 0, 4'b0000, 4'b0000, 1'b0),
            o(4'hE, 7'h40, 1), o(4'hD, 7'h40, 1), o(4'hB, 7'h40, 1), o(4'h7, 7'h40, 1));
    set_vec(7, mkcfg(5, 6, 7, 8, 4'b1111, 4'b0000, 1'b0),
            o(4'hE, 7'h00, 0), o(4'hD, 7'h78, 0), o(4'hB, 7'h02, 0), o(4'h7, 7'h12, 0));

    // Reset, then the first cycle after release must carry frame_tick.
    apply(vecs[0].cfg);
    sh = '0;
    do_reset(3);

    // Table: each configuration is displayed for one full frame; slot k is
    // checked mid-slot against the hand-derived pattern.
    for (int i = 0; i < 8; i++) begin
      apply(vecs[i].cfg);
      align_frame();
      for (int j = 0; j < FRAME; j++) begin
        at_neg();
        if (j % RD == 6) check($sformatf("table%0d_slot%0d", i, j / RD), vecs[i].want[j / RD]);
        to_next();
      end
    end

    // Shadow: a mid-frame change of digit0 and dp_mask waits for the next frame.
    apply(mkcfg(1, 2, 3, 4, 4'b0000, 4'b0000, 1'b0));
    align_frame();
    for (int j = 0; j < 2 * FRAME; j++) begin
      if (j == 3) apply(mkcfg(1, 2, 3, 9, 4'b0010, 4'b0000, 1'b0));
      at_neg();
      if (j == 6 || j == 8) check("shadow_hold", o(4'hE, 7'h19, 1));
      if (j == 14)          check("shadow_hold_dp", o(4'hD, 7'h30, 1));
      if (j == FRAME + 6)   check("shadow_new", o(4'hE, 7'h10, 1));
      if (j == FRAME + 14)  check("shadow_dp", o(4'hD, 7'h30, 0));
      to_next();
    end

    // Blink: digit0 shown two frames, hidden two frames, from reset release.
    apply(mkcfg(1, 2, 3, 4, 4'b0000, 4'b0001, 1'b0));
    do_reset(2);
    for (int f = 0; f < 8; f++) begin
      for (int j = 0; j < FRAME; j++) begin
        at_neg();
        if (j == 6) check($sformatf("blink_f%0d", f), (f % 4 < 2) ? o(4'hE, 7'h19, 1) : OFF);
        to_next();
      end
    end

    // Mid-frame reset at idx=2, cnt=5 while digit0 is in its hidden phase.
    while (!((t % FRAME == 21) && ((t / FRAME) % 4 >= 2))) cycle();
    do_reset(2);
    for (int j = 0; j < FRAME; j++) begin
      at_neg();
      if (j == 6) check("restart_digit0", o(4'hE, 7'h19, 1));
      to_next();
    end

    // Random inputs against the reference model.
    for (int n = 0; n < 24 * FRAME; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        for (int k = 0; k < 4; k++)
          c.d[k] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        c.dpm = 4'($urandom_range(0, 15));
        c.blm = 4'($urandom_range(0, 15));
        c.lzb = 1'($urandom_range(0, 1));
        apply(c);
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
